// File: rtl/motor_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : motor_frame_tx
// Description : Transmit-side framer for the motor command byte stream.
//               Latches NUM_MOTORS 7-bit commands on start and emits a frame
//               of header, data bytes and an XOR checksum over a
//               valid/ready byte interface. Only the header carries bit 7 = 1.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_frame_tx #(
  parameter int NUM_MOTORS = 4,
  parameter int SEQ_W      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7*NUM_MOTORS-1:0]   cmd_in,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int IDX_W = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOTORS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  state_t                     state, state_nx;
  logic [IDX_W-1:0]           idx, idx_nx;
  logic [7*NUM_MOTORS-1:0]    cmd_q, cmd_nx;
  logic [SEQ_W-1:0]           seq, seq_nx;
  logic [7:0]                 data_q, data_nx;
  logic                       done_q, done_nx;
  logic [6:0]                 chk;
  logic                       accept;

  // Valid and busy are both simply "not idle"; they come straight from the
  // state register so they are glitch-free and rise one cycle after start.
  assign tx_valid = (state != S_IDLE);
  assign busy     = (state != S_IDLE);
  assign tx_data  = data_q;
  assign done     = done_q;
  assign accept   = tx_valid & tx_ready;

  // Checksum over the latched commands, so cmd_in changes mid-frame are harmless.
  always_comb begin
    chk = '0;
    for (int k = 0; k < NUM_MOTORS; k++) begin
      chk = chk ^ cmd_q[7*k +: 7];
    end
  end

  // Next-state and next-byte logic; the byte register is loaded with the
  // content of the state being entered so tx_data holds through stalls.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cmd_nx   = cmd_q;
    seq_nx   = seq;
    data_nx  = data_q;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_HDR;
          cmd_nx   = cmd_in;
          idx_nx   = '0;
          data_nx  = 8'h80 | {{(8-SEQ_W){1'b0}}, seq};
        end
      end
      S_HDR: begin
        if (accept) begin
          state_nx = S_DATA;
          idx_nx   = '0;
          data_nx  = {1'b0, cmd_q[6:0]};
        end
      end
      S_DATA: begin
        if (accept) begin
          if (idx == LAST_IDX) begin
            state_nx = S_CHK;
            data_nx  = {1'b0, chk};
          end else begin
            idx_nx  = idx + 1'b1;
            data_nx = {1'b0, cmd_q[7*(int'(idx) + 1) +: 7]};
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
          seq_nx   = seq + SEQ_W'(1);
          data_nx  = 8'h00;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State, latched commands, sequence number and output byte registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      cmd_q  <= '0;
      seq    <= '0;
      data_q <= 8'h00;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      cmd_q  <= cmd_nx;
      seq    <= seq_nx;
      data_q <= data_nx;
      done_q <= done_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_motor_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_frame_tx
// Description : Self-checking bench for motor_frame_tx: a table of directed
//               frames followed by randomized frames checked against a
//               frame-level reference model (header/sequence, data, XOR).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_frame_tx;

  localparam int N  = 4;
  localparam int SW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7*N-1:0] cmd_in;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         done;

  int total  = 0;
  int passed = 0;
  int seq_m  = 0;

  motor_frame_tx #(.NUM_MOTORS(N), .SEQ_W(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cmd_in   (cmd_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  typedef struct {
    logic [7*N-1:0] cmds;
    int             stall;
    bit             mutate;
    int             gap;
    logic [7:0]     exp_hdr;
    logic [7:0]     exp_chk;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference checksum: plain XOR of the seven-bit commands.
  function automatic logic [7:0] model_chk(input logic [7*N-1:0] c);
    logic [6:0] x;
    x = 7'h00;
    for (int k = 0; k < N; k++) x = x ^ c[7*k +: 7];
    return {1'b0, x};
  endfunction

  function automatic logic [7:0] model_hdr();
    return 8'h80 | 8'(seq_m % (1 << SW));
  endfunction

  // Issue start at the current negedge and walk the whole frame, holding
  // tx_ready low for 'stall' cycles on every byte. Ends on the done cycle.
  task automatic run_frame(input logic [7*N-1:0] cmds, input int stall, input bit mutate,
                           input logic [7:0] exp_hdr, input logic [7:0] exp_chk);
    logic [7:0] exp_b [N+2];
    exp_b[0] = exp_hdr;
    for (int k = 0; k < N; k++) exp_b[k+1] = {1'b0, cmds[7*k +: 7]};
    exp_b[N+1] = exp_chk;
    start    = 1'b1;
    cmd_in   = cmds;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < N + 2; b++) begin
      if (mutate && b == 2) begin
        start  = 1'b1;
        cmd_in = {N{7'h55}};
      end else begin
        cmd_in = (7*N)'($urandom);
      end
      for (int s = 0; s <= stall; s++) begin
        tx_ready = (s == stall);
        check($sformatf("valid_b%0d", b), 32'(tx_valid), 32'd1);
        check($sformatf("data_b%0d", b), 32'(tx_data), 32'(exp_b[b]));
        check("busy_in_frame", 32'(busy), 32'd1);
        check("done_in_frame", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
      end
    end
    check("done_pulse", 32'(done), 32'd1);
    check("valid_after", 32'(tx_valid), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    seq_m = (seq_m + 1) % (1 << SW);
  endtask

  // Idle cycles after a frame: nothing may start and done must have dropped.
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      @(negedge clk);
      check("idle_valid", 32'(tx_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [7*N-1:0] c;
    // Directed frames: headers follow seq 0..5 from reset.
    tbl[0] = '{ {7'h08, 7'h04, 7'h02, 7'h01}, 0, 1'b0, 1, 8'h80, 8'h0F };
    tbl[1] = '{ {7'h00, 7'h00, 7'h00, 7'h7F}, 0, 1'b0, 1, 8'h81, 8'h7F };
    tbl[2] = '{ {7'h08, 7'h04, 7'h02, 7'h01}, 3, 1'b0, 2, 8'h82, 8'h0F };
    tbl[3] = '{ {7'h00, 7'h7F, 7'h2A, 7'h55}, 1, 1'b1, 3, 8'h83, 8'h00 };
    tbl[4] = '{ {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 0, 1'b0, 0, 8'h84, 8'h00 };
    tbl[5] = '{ {7'h08, 7'h44, 7'h22, 7'h11}, 2, 1'b0, 1, 8'h85, 8'h7F };

    rst      = 1'b1;
    start    = 1'b0;
    tx_ready = 1'b0;
    cmd_in   = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(tx_data), 32'h00);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].cmds, tbl[i].stall, tbl[i].mutate, tbl[i].exp_hdr, tbl[i].exp_chk);
      idle_check(tbl[i].gap);
    end

    // Random frames up to 16 since reset, then the header must wrap to 80.
    for (int r = 0; r < 10; r++) begin
      c = (7*N)'($urandom);
      run_frame(c, int'($urandom_range(0, 2)), 1'b0, model_hdr(), model_chk(c));
      idle_check(int'($urandom_range(0, 2)));
    end
    c = (7*N)'($urandom);
    run_frame(c, 0, 1'b0, 8'h80, model_chk(c));
    idle_check(1);

    // Reset while DATA(2) is being presented.
    c = {7'h33, 7'h4C, 7'h19, 7'h62};
    start    = 1'b1;
    cmd_in   = c;
    tx_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_data2", 32'(tx_data), 32'(c[14 +: 7]));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", 32'(tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_data", 32'(tx_data), 32'h00);
    seq_m = 0;
    idle_check(1);
    c = (7*N)'($urandom);
    run_frame(c, 1, 1'b0, 8'h80, model_chk(c));
    idle_check(1);

    for (int r = 0; r < 4; r++) begin
      c = (7*N)'($urandom);
      run_frame(c, int'($urandom_range(0, 3)), 1'b0, model_hdr(), model_chk(c));
      idle_check(int'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
